// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants and ALU operation encodings (decode side and ALU side).
package mips_pkg;

    typedef enum logic [4:0] {
        OP_AND = 5'b00000,
        OP_OR  = 5'b00001,
        OP_ADD = 5'b00010,
        OP_XOR = 5'b00011,
        OP_SUB = 5'b00110,
        OP_SLT = 5'b00111,
        OP_SLL = 5'b01000,
        OP_SRL = 5'b01001,
        OP_SRA = 5'b01010,
        OP_NOR = 5'b01100,
        OP_JAL = 5'b01101,
        OP_LUI = 5'b01110
    } ope_e;

    localparam logic [5:0] OPC_RTYPE    = 6'h00;
    localparam logic [5:0] OPC_JAL      = 6'h03;
    localparam logic [5:0] OPC_BEQ      = 6'h04;
    localparam logic [5:0] OPC_BNE      = 6'h05;
    localparam logic [5:0] OPC_ADDI     = 6'h08;
    localparam logic [5:0] OPC_ADDIU    = 6'h09;
    localparam logic [5:0] OPC_SLTI     = 6'h0A;
    localparam logic [5:0] OPC_ANDI     = 6'h0C;
    localparam logic [5:0] OPC_ORI      = 6'h0D;
    localparam logic [5:0] OPC_XORI     = 6'h0E;
    localparam logic [5:0] OPC_LUI      = 6'h0F;
    localparam logic [5:0] OPC_MEM_LO   = 6'h20;
    localparam logic [5:0] OPC_STORE_LO = 6'h28;
    localparam logic [5:0] OPC_MEM_HI   = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

endpackage

// File: rtl/alu_op_issue_if.sv
// Issue-stage bundle: upstream instruction channel plus downstream ALU operation channel.
// master drives instructions and ALU ready; slave is the issue stage.
interface alu_op_issue_if #(
    parameter int NB_BITS = 32,
    parameter int NB_OPE  = 5
);
    logic               valid;
    logic               ready;
    logic               flush;
    logic [31:0]        instr;
    logic [NB_BITS-1:0] pc4;
    logic [NB_BITS-1:0] rs_data;
    logic [NB_BITS-1:0] rt_data;
    logic               alu_valid;
    logic               alu_ready;
    logic [NB_OPE-1:0]  ope_sel;
    logic [NB_BITS-1:0] data_a;
    logic [NB_BITS-1:0] data_b;
    logic [4:0]         wr_reg;
    logic               reg_we;
    logic               illegal;

    modport master (
        output valid, flush, instr, pc4, rs_data, rt_data, alu_ready,
        input  ready, alu_valid, ope_sel, data_a, data_b, wr_reg, reg_we, illegal
    );

    modport slave (
        input  valid, flush, instr, pc4, rs_data, rt_data, alu_ready,
        output ready, alu_valid, ope_sel, data_a, data_b, wr_reg, reg_we, illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode: ALU select, operand muxes, destination, write enable, illegal flag.
// Zero latency, no state; unknown opcode/funct degrades to a non-writing ADD.
module alu_op_decode
    import mips_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_OPE  = 5
) (
    input  logic [31:0]        instr_i,
    input  logic [NB_BITS-1:0] pc4_i,
    input  logic [NB_BITS-1:0] rs_data_i,
    input  logic [NB_BITS-1:0] rt_data_i,
    output logic [NB_OPE-1:0]  ope_sel_o,
    output logic [NB_BITS-1:0] data_a_o,
    output logic [NB_BITS-1:0] data_b_o,
    output logic [4:0]         wr_reg_o,
    output logic               reg_we_o,
    output logic               illegal_o
);
    typedef enum logic [1:0] {A_RS, A_SHAMT, A_PC4} a_sel_e;
    typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT, B_ZERO} b_sel_e;

    instr_t f;
    ope_e   ope;
    a_sel_e a_sel;
    b_sel_e b_sel;
    logic   use_rd;
    logic   link;
    logic   writes;
    logic   legal;
    logic   unused_rs;

    assign f         = instr_i;
    assign unused_rs = ^f.rs;

    always_comb begin
        ope    = OP_ADD;
        a_sel  = A_RS;
        b_sel  = B_RT;
        use_rd = 1'b0;
        link   = 1'b0;
        writes = 1'b1;
        legal  = 1'b1;
        if (f.opcode == OPC_RTYPE) begin
            use_rd = 1'b1;
            case (f.funct)
                FN_SLL:  begin ope = OP_SLL; a_sel = A_SHAMT; end
                FN_SRL:  begin ope = OP_SRL; a_sel = A_SHAMT; end
                FN_SRA:  begin ope = OP_SRA; a_sel = A_SHAMT; end
                FN_SLLV: ope = OP_SLL;
                FN_SRLV: ope = OP_SRL;
                FN_SRAV: ope = OP_SRA;
                FN_JR:   begin ope = OP_ADD; writes = 1'b0; end
                FN_JALR: begin ope = OP_JAL; a_sel = A_PC4; b_sel = B_ZERO; end
                FN_ADDU: ope = OP_ADD;
                FN_SUBU: ope = OP_SUB;
                FN_AND:  ope = OP_AND;
                FN_OR:   ope = OP_OR;
                FN_XOR:  ope = OP_XOR;
                FN_NOR:  ope = OP_NOR;
                FN_SLT:  ope = OP_SLT;
                default: legal = 1'b0;
            endcase
        end else begin
            case (f.opcode)
                OPC_JAL:             begin ope = OP_JAL; a_sel = A_PC4; b_sel = B_ZERO; link = 1'b1; end
                OPC_BEQ, OPC_BNE:    begin ope = OP_SUB; writes = 1'b0; end
                OPC_ADDI, OPC_ADDIU: begin ope = OP_ADD; b_sel = B_SEXT; end
                OPC_SLTI:            begin ope = OP_SLT; b_sel = B_SEXT; end
                OPC_ANDI:            begin ope = OP_AND; b_sel = B_ZEXT; end
                OPC_ORI:             begin ope = OP_OR;  b_sel = B_ZEXT; end
                OPC_XORI:            begin ope = OP_XOR; b_sel = B_ZEXT; end
                OPC_LUI:             begin ope = OP_LUI; b_sel = B_ZEXT; end
                default: begin
                    // Loads and stores share the address add; stores never write back.
                    if (f.opcode >= OPC_MEM_LO && f.opcode <= OPC_MEM_HI) begin
                        ope    = OP_ADD;
                        b_sel  = B_SEXT;
                        writes = (f.opcode < OPC_STORE_LO);
                    end else begin
                        legal = 1'b0;
                    end
                end
            endcase
        end
        if (!legal) begin
            ope    = OP_ADD;
            a_sel  = A_RS;
            b_sel  = B_RT;
            writes = 1'b0;
        end
    end

    always_comb begin
        case (a_sel)
            A_SHAMT: data_a_o = {{(NB_BITS-5){1'b0}}, f.shamt};
            A_PC4:   data_a_o = pc4_i;
            default: data_a_o = rs_data_i;
        endcase
        case (b_sel)
            B_SEXT:  data_b_o = {{(NB_BITS-16){instr_i[15]}}, instr_i[15:0]};
            B_ZEXT:  data_b_o = {{(NB_BITS-16){1'b0}}, instr_i[15:0]};
            B_ZERO:  data_b_o = '0;
            default: data_b_o = rt_data_i;
        endcase
    end

    assign wr_reg_o  = link ? REG_RA : (use_rd ? f.rd : f.rt);
    assign reg_we_o  = writes && (wr_reg_o != 5'd0);
    assign illegal_o = !legal;
    assign ope_sel_o = NB_OPE'(ope);

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: decoded op and operands land in one output register, o_valid one cycle after accept.
// o_ready = ~o_valid | i_ready; a held op stalls upstream until taken; flush kills held and incoming ops.
module alu_op_issue
    import mips_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_OPE  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic [NB_BITS-1:0] i_pc4,
    input  logic [NB_BITS-1:0] i_rs_data,
    input  logic [NB_BITS-1:0] i_rt_data,
    input  logic               i_flush,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [NB_OPE-1:0]  o_ope_sel,
    output logic [NB_BITS-1:0] o_data_a,
    output logic [NB_BITS-1:0] o_data_b,
    output logic [4:0]         o_wr_reg,
    output logic               o_reg_we,
    output logic               o_illegal
);
    typedef struct packed {
        logic [NB_OPE-1:0]  ope_sel;
        logic [NB_BITS-1:0] data_a;
        logic [NB_BITS-1:0] data_b;
        logic [4:0]         wr_reg;
        logic               reg_we;
        logic               illegal;
    } issue_t;

    logic [NB_OPE-1:0]  dec_ope_sel;
    logic [NB_BITS-1:0] dec_data_a;
    logic [NB_BITS-1:0] dec_data_b;
    logic [4:0]         dec_wr_reg;
    logic               dec_reg_we;
    logic               dec_illegal;

    issue_t dec;
    issue_t out_q, out_d;
    logic   valid_q, valid_d;
    logic   accept;

    alu_op_decode #(.NB_BITS(NB_BITS), .NB_OPE(NB_OPE)) u_decode (
        .instr_i   (i_instr),
        .pc4_i     (i_pc4),
        .rs_data_i (i_rs_data),
        .rt_data_i (i_rt_data),
        .ope_sel_o (dec_ope_sel),
        .data_a_o  (dec_data_a),
        .data_b_o  (dec_data_b),
        .wr_reg_o  (dec_wr_reg),
        .reg_we_o  (dec_reg_we),
        .illegal_o (dec_illegal)
    );

    assign dec = '{ope_sel: dec_ope_sel, data_a: dec_data_a, data_b: dec_data_b,
                   wr_reg: dec_wr_reg, reg_we: dec_reg_we, illegal: dec_illegal};

    assign o_ready = ~valid_q | i_ready;
    assign accept  = i_valid & o_ready & ~i_flush;

    // Payload only loads on accept, so bubbles and flushes leave the ALU inputs quiet.
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            out_d   = dec;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= 1'b0;
            out_q         <= '0;
            out_q.ope_sel <= NB_OPE'(OP_AND);
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_ope_sel = out_q.ope_sel;
    assign o_data_a  = out_q.data_a;
    assign o_data_b  = out_q.data_b;
    assign o_wr_reg  = out_q.wr_reg;
    assign o_reg_we  = out_q.reg_we;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: table-driven reference decoder, random traffic with stalls and
// flushes, directed corner cases and an asynchronous reset during a stall.
module tb_alu_op_issue;
    localparam int NB_BITS = 32;
    localparam int NB_OPE  = 5;

    typedef struct packed {
        logic [4:0]  ope;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wr;
        logic        we;
        logic        ill;
    } exp_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    always #5 i_clk = ~i_clk;

    alu_op_issue_if #(.NB_BITS(NB_BITS), .NB_OPE(NB_OPE)) bus ();

    alu_op_issue #(.NB_BITS(NB_BITS), .NB_OPE(NB_OPE)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (bus.valid),
        .o_ready   (bus.ready),
        .i_instr   (bus.instr),
        .i_pc4     (bus.pc4),
        .i_rs_data (bus.rs_data),
        .i_rt_data (bus.rt_data),
        .i_flush   (bus.flush),
        .i_ready   (bus.alu_ready),
        .o_valid   (bus.alu_valid),
        .o_ope_sel (bus.ope_sel),
        .o_data_a  (bus.data_a),
        .o_data_b  (bus.data_b),
        .o_wr_reg  (bus.wr_reg),
        .o_reg_we  (bus.reg_we),
        .o_illegal (bus.illegal)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [4:0] r_ops [int];
    logic [4:0] i_ops [int];
    bit   rand_rdy = 1'b0;
    int   fn_tab [15] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h09, 'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A};
    int   op_tab [16] = '{'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F, 'h20, 'h23, 'h25, 'h27, 'h28, 'h2B};

    function automatic void chk(string name, logic [95:0] act, logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endfunction

    // Reference decoder: opcode/funct lookup tables plus operand rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc4,
                                   input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        int opc = int'(ins[31:26]);
        int fn  = int'(ins[5:0]);
        logic [4:0] rt_f = ins[20:16];
        logic [4:0] rd_f = ins[15:11];
        e = '{ope: 5'b00010, a: rs, b: rt, wr: 5'd0, we: 1'b0, ill: 1'b1};
        if (opc == 0 && r_ops.exists(fn)) begin
            e.ope = r_ops[fn];
            e.ill = 1'b0;
            e.wr  = rd_f;
            e.a   = (fn == 0 || fn == 2 || fn == 3) ? 32'(ins[10:6]) : (fn == 9) ? pc4 : rs;
            e.b   = (fn == 9) ? 32'd0 : rt;
            e.we  = (fn != 8) && (rd_f != 0);
        end else if (opc != 0 && i_ops.exists(opc)) begin
            e.ope = i_ops[opc];
            e.ill = 1'b0;
            if (opc == 3) begin
                e.a = pc4; e.b = 32'd0; e.wr = 5'd31; e.we = 1'b1;
            end else begin
                e.a  = rs;
                e.wr = rt_f;
                if (opc == 4 || opc == 5)          e.b = rt;
                else if (opc >= 'h0C && opc <= 'h0F) e.b = 32'(ins[15:0]);
                else                               e.b = 32'($signed(ins[15:0]));
                e.we = (rt_f != 0) && !(opc == 4 || opc == 5) && (opc < 'h28);
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs = 5'($urandom);
        logic [4:0] rt = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        logic [4:0] rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        logic [31:0] ins;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: ins = {6'd0, rs, rt, rd, 5'($urandom), 6'(fn_tab[$urandom_range(0, 14)])};
            9:          ins = $urandom;
            default:    ins = {6'(op_tab[$urandom_range(0, 15)]), rs, rt, 16'($urandom)};
        endcase
        return ins;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc4,
                         input logic [31:0] rs, input logic [31:0] rt);
        bit done = 1'b0;
        bus.valid = 1'b1; bus.instr = ins; bus.pc4 = pc4; bus.rs_data = rs; bus.rt_data = rt;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge i_clk);
            if (bus.ready && !bus.flush) begin
                sb.push_back(model(ins, pc4, rs, rt));
                done = 1'b1;
            end
        end
        if (!done) fail("issue_accept");
        @(posedge i_clk); #1;
        bus.valid = 1'b0;
    endtask

    task automatic flush_cycle(input logic [31:0] ins);
        bus.flush = 1'b1; bus.valid = 1'b1; bus.instr = ins;
        @(posedge i_clk); #1;
        bus.flush = 1'b0; bus.valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [4:0] ope, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] wr, input logic we);
        chk({tag, "_valid"}, bus.alu_valid, 1'b1);
        chk({tag, "_ope"},   bus.ope_sel, ope);
        chk({tag, "_a"},     bus.data_a, a);
        chk({tag, "_b"},     bus.data_b, b);
        chk({tag, "_wr"},    bus.wr_reg, wr);
        chk({tag, "_we"},    bus.reg_we, we);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus.alu_valid, 1'b0);
        chk({tag, "_ope"},   bus.ope_sel, 5'b00000);
        chk({tag, "_a"},     bus.data_a, 32'd0);
        chk({tag, "_b"},     bus.data_b, 32'd0);
        chk({tag, "_wr"},    bus.wr_reg, 5'd0);
        chk({tag, "_we"},    bus.reg_we, 1'b0);
        chk({tag, "_ill"},   bus.illegal, 1'b0);
    endtask

    always @(posedge i_clk) begin
        #1;
        if (rand_rdy) bus.alu_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: handshake rules, payload stability, and scoreboard compare on every ALU take.
    logic [75:0] p_pay;
    logic        p_vld, p_rdy, p_flush, p_acc;
    bit          have_prev = 1'b0;

    always @(negedge i_clk) begin
        logic [75:0] pay;
        exp_t        e;
        pay = {bus.ope_sel, bus.data_a, bus.data_b, bus.wr_reg, bus.reg_we, bus.illegal};
        if (!i_rst_n) begin
            sb.delete();
            have_prev = 1'b0;
        end else begin
            chk("o_ready_rule", bus.ready, !bus.alu_valid || bus.alu_ready);
            if (have_prev) begin
                if (p_flush)              chk("valid_after_flush", bus.alu_valid, 1'b0);
                else if (p_acc)           chk("valid_latency", bus.alu_valid, 1'b1);
                else if (p_vld && p_rdy)  chk("valid_drain", bus.alu_valid, 1'b0);
                else                      chk("valid_hold", bus.alu_valid, p_vld);
                if (!p_acc) chk("payload_hold", pay, p_pay);
            end
            if (bus.alu_valid && bus.flush) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (bus.alu_valid && bus.alu_ready) begin
                if (sb.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    chk("sb_ope_sel", bus.ope_sel, e.ope);
                    chk("sb_illegal", bus.illegal, e.ill);
                    chk("sb_reg_we",  bus.reg_we, e.we);
                    if (!e.ill) begin
                        chk("sb_data_a", bus.data_a, e.a);
                        chk("sb_data_b", bus.data_b, e.b);
                    end
                    if (e.we) chk("sb_wr_reg", bus.wr_reg, e.wr);
                end
            end
            p_vld = bus.alu_valid; p_rdy = bus.alu_ready; p_flush = bus.flush;
            p_acc = bus.valid && bus.ready && !bus.flush;
            p_pay = pay;
            have_prev = 1'b1;
        end
    end

    initial begin
        r_ops[0] = 5'b01000; r_ops[4] = 5'b01000; r_ops[2] = 5'b01001; r_ops[6] = 5'b01001;
        r_ops[3] = 5'b01010; r_ops[7] = 5'b01010; r_ops['h21] = 5'b00010; r_ops['h23] = 5'b00110;
        r_ops['h24] = 5'b00000; r_ops['h25] = 5'b00001; r_ops['h26] = 5'b00011; r_ops['h27] = 5'b01100;
        r_ops['h2A] = 5'b00111; r_ops[9] = 5'b01101; r_ops[8] = 5'b00010;
        i_ops[8] = 5'b00010; i_ops[9] = 5'b00010; i_ops['h0A] = 5'b00111; i_ops['h0C] = 5'b00000;
        i_ops['h0D] = 5'b00001; i_ops['h0E] = 5'b00011; i_ops['h0F] = 5'b01110; i_ops[4] = 5'b00110;
        i_ops[5] = 5'b00110; i_ops[3] = 5'b01101;
        for (int k = 'h20; k <= 'h2B; k++) i_ops[k] = 5'b00010;

        bus.valid = 1'b0; bus.flush = 1'b0; bus.alu_ready = 1'b0;
        bus.instr = '0; bus.pc4 = '0; bus.rs_data = '0; bus.rt_data = '0;
        #1 i_rst_n = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        bus.alu_ready = 1'b1;

        issue(32'h2508FFFF, 32'h100, 32'd5, 32'd7);
        check_out("addiu", 5'b00010, 32'd5, 32'hFFFFFFFF, 5'd8, 1'b1);
        issue(32'h00084080, 32'h104, 32'd9, 32'd3);
        check_out("sll", 5'b01000, 32'd2, 32'd3, 5'd8, 1'b1);
        issue(32'h0C000010, 32'h104, 32'd9, 32'd3);
        check_out("jal", 5'b01101, 32'h104, 32'd0, 5'd31, 1'b1);
        @(posedge i_clk); #1;

        // Stall: ORI held while a SUBU waits upstream.
        bus.alu_ready = 1'b0;
        issue(32'h3508F0F0, 32'h200, 32'h11, 32'h22);
        fork
            issue({6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h23}, 32'h204, 32'd50, 32'd8);
        join_none
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("stall_ready", bus.ready, 1'b0);
            chk("stall_data_b", bus.data_b, 32'h0000F0F0);
            chk("stall_ope", bus.ope_sel, 5'b00001);
        end
        @(posedge i_clk); #1;
        bus.alu_ready = 1'b1;
        wait fork;
        check_out("after_stall", 5'b00110, 32'd50, 32'd8, 5'd6, 1'b1);

        flush_cycle(32'h25080001);
        chk("flush_valid", bus.alu_valid, 1'b0);
        issue(32'hFD2A1234, 32'h300, 32'hDEADBEEF, 32'h12345678);
        chk("illegal_flag", bus.illegal, 1'b1);
        chk("illegal_we", bus.reg_we, 1'b0);
        chk("illegal_ope", bus.ope_sel, 5'b00010);

        // Reset between edges while the illegal op is stalled.
        bus.alu_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        bus.alu_ready = 1'b1;
        issue(32'h3508F0F0, 32'h400, 32'h11, 32'h22);
        check_out("post_reset", 5'b00001, 32'h11, 32'h0000F0F0, 5'd8, 1'b1);

        rand_rdy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) flush_cycle(rand_instr());
            else issue(rand_instr(), $urandom & 32'hFFFFFFFC, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk); #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge i_clk); #1;
        bus.alu_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
